synch_fifo_v2: RTL
==================

SYNCH_FIFO_V2 -- requirements
Module: synch_fifo_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of words; power of two, 4 or greater.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full level.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty level.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port rd_en, input, 1 bit: read request.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: occupancy flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: words stored.
REQ-014 SHALL have ports overflow and underflow, each output, 1 bit: registered one-cycle error pulses.

Function
REQ-015 SHALL reject illegal parameters at elaboration: DEPTH not a power of two, or not 1 <= AE_THRESH < AF_THRESH <= DEPTH-1.
REQ-016 SHALL define rd_acc = rd_en && !empty.
REQ-017 SHALL define wr_acc = wr_en && (!full || rd_acc), so a write is accepted while full when a read is accepted in the same cycle.
REQ-018 SHALL update count as: wr_acc only -> +1; rd_acc only -> -1; both or neither -> unchanged.
REQ-019 SHALL keep count within 0..DEPTH at all times.
REQ-020 SHALL decode flags from the registered count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-021 SHALL use $clog2(DEPTH)-bit write and read pointers that advance by 1 on wr_acc and rd_acc respectively and wrap from DEPTH-1 to 0.
REQ-022 SHALL, on wr_acc, write data_in into mem[wr_ptr] at the clock edge.
REQ-023 SHALL, when FWFT=0, register mem[rd_ptr] into data_out on rd_acc, so data is valid the cycle after the accepted read; data_out holds its value otherwise.
REQ-024 SHALL, when FWFT=1, drive data_out = mem[rd_ptr] combinationally; it is valid whenever empty=0 and is don't-care while empty=1.
REQ-025 SHALL, when FWFT=1, deassert empty the cycle after the first write into an empty FIFO, with data_out equal to that word in the same cycle.
REQ-026 SHALL, on simultaneous read and write while empty, accept the write, reject the read and pulse underflow; no pass-through.
REQ-027 SHALL, on simultaneous read and write while full, accept both and leave count at DEPTH.
REQ-028 SHALL pulse overflow for exactly one cycle, the cycle after wr_en=1 && !wr_acc.
REQ-029 SHALL pulse underflow for exactly one cycle, the cycle after rd_en=1 && empty.
REQ-030 SHALL leave state unchanged by a rejected request.

Reset
REQ-031 SHALL, at a rising clk edge with rst_n=0, clear wr_ptr, rd_ptr, count, overflow, underflow and data_out (to 0).
REQ-032 SHALL therefore show, after reset, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-033 SHALL take reset with priority over any wr_en or rd_en in the same cycle.
REQ-034 SHALL discard stored words on a reset mid-operation; memory contents need not be cleared and are never observable.

Structure
REQ-035 SHALL place the default DATA_WIDTH, DEPTH and threshold constants, and a pointer-width helper function, in shared package synch_fifo_pkg.
REQ-036 SHALL implement storage as sub-module synch_fifo_mem: one write port and an asynchronous read port, no reset.

Verification
REQ-037 SHALL cover: reset, then write 0x01..0x10 with DEPTH=16 -> full=1 after the 16th write, count=16, almost_full first asserted at count=14.
REQ-038 SHALL cover: a 17th write while full with rd_en=0 -> overflow pulses one cycle, count stays 16, data unchanged.
REQ-039 SHALL cover: draining 16 words with FWFT=0 -> data_out 0x01..0x10 in order, each one cycle after rd_en; a 17th read gives an underflow pulse and data_out stays 0x10.
REQ-040 SHALL cover: wr_en=rd_en=1 while full -> count stays 16, read returns the oldest word, no overflow; the same while empty -> count becomes 1, underflow pulses.
REQ-041 SHALL cover: FWFT=1, a single write of 0xA5 -> next cycle empty=0 and data_out=0xA5 with no read issued.
REQ-042 SHALL cover: 40 mixed random operations across pointer wrap, then rst_n=0 for one cycle mid-stream -> count=0, empty=1, data_out=0, and the scoreboard matches throughout.

Source files
------------

// File: rtl/synch_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO: default geometry,
// occupancy thresholds and the pointer-width helper used by top and storage.
package synch_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AF_THRESH  = DEF_DEPTH - 2;
  localparam int DEF_AE_THRESH  = 2;

  // Pointer width for a given word count; never collapses below one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/synch_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// No reset; stale contents are never visible because the pointers gate reads.
module synch_fifo_mem
  import synch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synch_fifo_v2.sv
// Single-clock FIFO with occupancy flags, registered error pulses and a
// selectable registered-read or first-word-fall-through output.
module synch_fifo_v2
  import synch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("synch_fifo_v2: DEPTH must be a power of two and at least 4");
  end
  if (!((AE_THRESH >= 1) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH - 1))) begin : g_bad_thresh
    $error("synch_fifo_v2: need 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Request/accept semantics: a read is accepted whenever the FIFO holds a
  // word; a write is accepted when not full, or when full but a read is
  // accepted in the same cycle. Rejected requests change nothing but raise
  // the matching error pulse on the following cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
    end
  end

  synch_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PW         (PW)
  ) u_mem (
    .clk     (clk),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is visible as soon as it is counted; meaningless while empty.
    assign data_out = rd_data;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (rd_acc) begin
        data_q <= rd_data;
      end
    end
    assign data_out = data_q;
  end

endmodule
